// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder for one channel: stage 1 minimises transitions (q_m),
// stage 2 DC-balances against the running disparity and emits the 10-bit symbol.
module tmds_encoder #(
  parameter logic [9:0] RST_TOKEN = 10'b1101010100,
  parameter int         DISPW     = 6
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    de,
  input  logic [7:0]              din,
  input  logic [1:0]              ctrl,
  output logic [9:0]              tout,
  output logic signed [DISPW-1:0] disparity
);

  // Streaming pipeline with no handshake: one input is accepted and one symbol is
  // emitted on every clock, with a fixed two-cycle latency from de/din/ctrl to tout.

  localparam logic signed [DISPW-1:0] ZERO  = '0;
  localparam logic signed [DISPW-1:0] TWO   = DISPW'(2);
  localparam logic signed [DISPW-1:0] EIGHT = DISPW'(8);

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n;
    logic       use_xnor;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0]              qm;
  logic                    de_q;
  logic [1:0]              ctrl_q;
  logic signed [DISPW-1:0] cnt;

  logic [9:0]              tout_next;
  logic signed [DISPW-1:0] cnt_next;
  logic [3:0]              n1;
  logic signed [DISPW-1:0] n1_s;
  logic signed [DISPW-1:0] diff;
  logic                    qm8;

  always_comb begin
    tout_next = RST_TOKEN;
    cnt_next  = cnt;
    n1        = ones8(qm[7:0]);
    n1_s      = DISPW'(n1);
    diff      = n1_s + n1_s - EIGHT;  // n1 - n0
    qm8       = qm[8];
    if (!de_q) begin
      case (ctrl_q)
        2'b00:   tout_next = 10'b1101010100;
        2'b01:   tout_next = 10'b0010101011;
        2'b10:   tout_next = 10'b0101010100;
        default: tout_next = 10'b1010101011;
      endcase
      cnt_next = ZERO;
    end else if ((cnt == ZERO) || (n1 == 4'd4)) begin
      tout_next = {~qm8, qm8, qm8 ? qm[7:0] : ~qm[7:0]};
      cnt_next  = qm8 ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > ZERO) && (n1 > 4'd4)) || ((cnt < ZERO) && (n1 < 4'd4))) begin
      tout_next = {1'b1, qm8, ~qm[7:0]};
      cnt_next  = cnt - diff + (qm8 ? TWO : ZERO);
    end else begin
      tout_next = {1'b0, qm8, qm[7:0]};
      cnt_next  = cnt + diff - (qm8 ? ZERO : TWO);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      qm     <= '0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      tout   <= RST_TOKEN;
      cnt    <= ZERO;
    end else begin
      qm     <= min_trans(din);
      de_q   <= de;
      ctrl_q <= ctrl;
      tout   <= tout_next;
      cnt    <= cnt_next;
    end
  end

  assign disparity = cnt;

endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Per-channel DVI 1.0 TMDS 8b/10b encoder for the HDMI/DVI output path.
- Consumes one 8-bit board colour channel (or the sync control pair during blanking) each pixel clock.
- Produces the 10-bit DC-balanced symbol for the 10:1 serializer feeding the TMDS output pins.
- Three instances per display output: ch0 = blue + {vsync,hsync}; ch1 = green; ch2 = red, ctrl tied to 00.

Parameters:
- RST_TOKEN, 10'b1101010100: symbol driven on tout during reset; the ctrl=00 token.
- DISPW, 6: width of the signed running-disparity register.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst_pix_n  in  1  reset, synchronous, active-low.
- de  in  1  data enable; 1 = active video, 0 = blanking.
- din  in  8  pixel channel data, sampled when de=1.
- ctrl  in  2  control bits {c1,c0}, sampled when de=0.
- tout  out  10  TMDS symbol; bit 0 is transmitted first.
- disparity  out  DISPW  signed running disparity after the symbol currently on tout (debug/verification).

Behaviour:
- Single clock domain; all state updates on posedge clk_pix.
- Reset: rst_pix_n=0 sampled at a clock edge gives, at that edge:
  - tout=RST_TOKEN, disparity=0.
  - Stage-1 registers cleared; stage-1 de=0, ctrl=00.
  - Reset mid-stream discards all in-flight symbols.
  - The first input after release appears 2 cycles later.
- Latency: fixed 2 cycles from de/din/ctrl to tout. No stalls, no handshake; one symbol per cycle, always.
- Stage 1, registered q_m[8:0], plus de and ctrl delayed one cycle:
  - n1d = popcount(din), 0..8.
  - XNOR path when n1d>4, or n1d==4 and din[0]==0:
    - q_m[0]=din[0].
    - q_m[i]=~(q_m[i-1]^din[i]) for i=1..7.
    - q_m[8]=0.
  - XOR path otherwise: same chain with XOR, q_m[8]=1.
  - Stage 1 computes q_m regardless of de; stage 2 ignores it when de=0.
- Stage 2 uses n1 = popcount(q_m[7:0]), n0 = 8-n1, and cnt = disparity register (signed).
  - de=0:
    - tout = token for ctrl: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
    - cnt <= 0.
  - de=1 and (cnt==0 or n1==n0):
    - tout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - de=1 and ((cnt>0 and n1>n0) or (cnt<0 and n0>n1)):
    - tout = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0-n1).
  - Otherwise with de=1:
    - tout = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1-n0) - 2*(~q_m[8]).
- Arithmetic and width rules:
  - All disparity arithmetic is signed DISPW bits.
  - cnt is always even and never overflows; the algorithm bounds it to -8..+8, and DISPW=6 gives margin.
  - disparity is updated on the same edge as tout.
- Boundary conditions:
  - de toggling on consecutive cycles: each symbol is encoded per its own de; the disparity clear takes effect for the next data symbol.
  - ctrl changing during de=1 has no effect.
  - din is don't-care during de=0.

Test Plan:
- Reset: hold rst_pix_n=0 for 3 cycles with de=1, din=8'hAA -> tout=10'b1101010100 and disparity=0 throughout; the first post-release input appears exactly 2 cycles after release.
- Control tokens: de=0, ctrl stepped 00,01,10,11 on consecutive cycles -> tout = 0x354, 0x0AB, 0x154, 0x2AB on cycles 2..5; disparity=0.
- Zero run from cnt=0: de=1, din=8'h00 for 3 cycles -> tout = 0x100, 0x3FF, 0x100; disparity = -8, +2, -6.
- All ones from cnt=0: one cycle of de=0, then de=1, din=8'hFF -> tout=0x200, disparity=-8. Then de=0 with ctrl=00 -> tout=0x354, disparity=0.
- Reset mid-stream: random data with de=1, pulse rst_pix_n=0 for 1 cycle -> tout=RST_TOKEN and disparity=0 on the next edge. Symbols issued in the 2 cycles before the pulse never appear.
- Soak: 100k cycles of random din with randomized blanking intervals against a bit-exact DVI 1.0 reference model -> tout matches every cycle. Also check:
  - disparity stays even and within -8..+8;
  - the 10:1-deserialized stream decodes back to din/ctrl.
